regfile_mc: RTL
===============

# regfile_mc

Parametrised, clocked register file for the multicycle datapath: two read ports, one write port, hardwired-zero register option, and built-in A/B operand latches. Read data is captured into the A/B output registers under per-port enables, so the decode stage loads operands in one cycle. A same-cycle write to the same register is bypassed into the latch. It replaces the per-register slot modules with a single array addressed by `rs`/`rt`/`rd`.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: register index width.
- `DEPTH`, 2**`ADDR_W`: number of registers; must satisfy `DEPTH` ≤ 2**`ADDR_W`.
- `ZERO_REG`, 1: when 1, register 0 always reads 0 and ignores writes.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rs` in `ADDR_W`: read index, port A.
- `rt` in `ADDR_W`: read index, port B.
- `rd` in `ADDR_W`: write index.
- `we` in 1: write enable.
- `i_data` in `DATA_W`: write data.
- `a_en` in 1: capture port A into `out_data_a`.
- `b_en` in 1: capture port B into `out_data_b`.
- `out_data_a` out `DATA_W`: latched operand A.
- `out_data_b` out `DATA_W`: latched operand B.

## Operation
- Storage: `DEPTH` × `DATA_W` array `mem`.
- Write: at a rising edge with `we`=1, `rst`=0 and `rd` < `DEPTH`, `mem[rd]` takes `i_data`.
  - When `ZERO_REG`=1 and `rd`=0, the write is dropped.
  - A write to `rd` ≥ `DEPTH` is dropped silently.
- Effective read of index `x`, denoted `rdval(x)`, is evaluated in this priority order:
  1. 0 if `ZERO_REG`=1 and `x`=0.
  2. 0 if `x` ≥ `DEPTH`.
  3. `i_data` (bypass) if `we`=1 and `rd`=`x` in the same cycle.
  4. Otherwise `mem[x]`.
- Capture: at a rising edge with `a_en`=1, `out_data_a` takes `rdval(rs)`. Likewise `b_en` loads `out_data_b` with `rdval(rt)`.
- Hold: with the enable low, each output holds its value indefinitely, including across writes to the register it was loaded from.
- `a_en`, `b_en` and `we` are fully independent. Any combination may be active in the same cycle.
- No state machine; the only state is the array plus two output registers.

## Timing
- Reset: while `rst`=1 at a rising edge:
  - every `mem` entry clears to 0;
  - `out_data_a` = 0 and `out_data_b` = 0;
  - `we`, `a_en` and `b_en` are ignored in that cycle.
- Reset wins over a simultaneous write or capture. The first cycle after `rst` falls behaves normally.
- Write latency: data written at edge N is visible through `mem` to captures at edge N+1 or later.
- Read latency: one cycle. With `rs`/`a_en` presented before edge N, `out_data_a` is valid after edge N.
- Read-during-write to the same index: the capture returns the new `i_data` (bypass), never the old contents.
- Write to register 0 with capture of register 0 (`ZERO_REG`=1): the capture yields 0. Neither the bypass nor `mem` is affected.
- `rs`=`rt` with both enables set: both outputs load the identical value.
- Outputs are registered only. There is no combinational path from inputs to `out_data_a` or `out_data_b`.

## Test plan
- Reset clear:
  - Stimulus: write 0xDEADBEEF to r6, assert `rst` one cycle, then capture `rs`=6, `rt`=6.
  - Required: both outputs read 0x00000000. During reset, both outputs read 0 regardless of enables.
- Write/read:
  - Stimulus: write r6=0x12345678 and r31=0xFFFFFFFF on consecutive cycles, then capture `rs`=6, `rt`=31.
  - Required: A=0x12345678 and B=0xFFFFFFFF one cycle after the capture edge.
- Bypass:
  - Stimulus: in the same cycle, `we`=1, `rd`=9, `i_data`=0xA5A5A5A5, `rs`=9, `a_en`=1; r9 previously held 0x11111111.
  - Required: A=0xA5A5A5A5, and r9 holds 0xA5A5A5A5 afterwards.
- Zero register:
  - Stimulus: write 0xCAFEF00D to r0 while `a_en`=1, `rs`=0; capture r0 again on the next cycle.
  - Required: both captures return 0. With `ZERO_REG`=0, the second capture returns 0xCAFEF00D.
- Hold and reset priority:
  - Stimulus: capture r6 (0x55) into A, drop `a_en`, write r6=0x77, then assert `rst` together with `we`=1, `rd`=3, `i_data`=0x99, `a_en`=1.
  - Required: A stays 0x55 until the reset edge. After reset, A=0 and r3=0.
- Parameter sweep:
  - Stimulus: `DATA_W`=16, `ADDR_W`=4, `DEPTH`=12; write r11=0xBEEF and r13=0x1234, then capture `rs`=11, `rt`=13.
  - Required: A=0xBEEF and B=0x0000.

Source files
------------

// File: rtl/regfile_mc.sv
// Multicycle-datapath register file: one write port, two read ports whose results
// are captured into the A/B operand registers, with same-cycle write bypass.
module regfile_mc #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 2 ** ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic              we,
    input  logic [DATA_W-1:0] i_data,
    input  logic              a_en,
    input  logic              b_en,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  wr_sel;

    logic [DATA_W-1:0] out_a_reg, out_a_next;
    logic [DATA_W-1:0] out_b_reg, out_b_next;

    // Per-row write decode; a hardwired-zero row never gets a select.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_row
            localparam bit WRITABLE = !((ZERO_REG != 0) && (gi == 0));
            assign wr_sel[gi] = WRITABLE && we && (rd == ADDR_W'(gi));
        end
    endgenerate

    // Whole array clears on reset, so it is built from flops rather than block RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem[i] <= i_data;
                end
            end
        end
    end

    logic              a_zero, a_oor, a_byp;
    logic              b_zero, b_oor, b_byp;
    logic [ADDR_W-1:0] a_idx, b_idx;
    logic [DATA_W-1:0] a_val, b_val;

    // Effective read value: hardwired zero, out-of-range zero, bypass, then array.
    always_comb begin
        a_zero = (ZERO_REG != 0) && (rs == '0);
        a_oor  = ({1'b0, rs} >= DEPTH_EXT);
        a_byp  = we && (rd == rs);
        a_idx  = a_oor ? '0 : rs;
        a_val  = mem[a_idx];
        if (a_zero || a_oor) begin
            a_val = '0;
        end else if (a_byp) begin
            a_val = i_data;
        end

        b_zero = (ZERO_REG != 0) && (rt == '0);
        b_oor  = ({1'b0, rt} >= DEPTH_EXT);
        b_byp  = we && (rd == rt);
        b_idx  = b_oor ? '0 : rt;
        b_val  = mem[b_idx];
        if (b_zero || b_oor) begin
            b_val = '0;
        end else if (b_byp) begin
            b_val = i_data;
        end
    end

    always_comb begin
        out_a_next = out_a_reg;
        out_b_next = out_b_reg;
        if (a_en) begin
            out_a_next = a_val;
        end
        if (b_en) begin
            out_b_next = b_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_a_reg <= '0;
            out_b_reg <= '0;
        end else begin
            out_a_reg <= out_a_next;
            out_b_reg <= out_b_next;
        end
    end

    assign out_data_a = out_a_reg;
    assign out_data_b = out_b_reg;

endmodule
